// File: rtl/l2req_core_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : l2req_core_arbiter
// Purpose  : Round-robin arbiter sharing the L2 request port among NUM_CORES
//            cores. Optional perf counters: define L2REQ_ARB_PERF_COUNTERS_EN.
// Revision : 1.0  initial release
// =============================================================================
module l2req_core_arbiter #(
    parameter int NUM_CORES     = 4,
    parameter int CORE_ID_WIDTH = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [NUM_CORES-1:0]        core_l2req_valid_i,
    input  logic [2*NUM_CORES-1:0]      core_l2req_strand_i,
    input  logic [2*NUM_CORES-1:0]      core_l2req_unit_i,
    input  logic [3*NUM_CORES-1:0]      core_l2req_op_i,
    input  logic [2*NUM_CORES-1:0]      core_l2req_way_i,
    input  logic [26*NUM_CORES-1:0]     core_l2req_address_i,
    input  logic [512*NUM_CORES-1:0]    core_l2req_data_i,
    input  logic [64*NUM_CORES-1:0]     core_l2req_mask_i,
    output logic [NUM_CORES-1:0]        core_l2req_ack_o,
    output logic                        l2req_valid_o,
    output logic [1:0]                  l2req_strand_o,
    output logic [1:0]                  l2req_unit_o,
    output logic [2:0]                  l2req_op_o,
    output logic [1:0]                  l2req_way_o,
    output logic [25:0]                 l2req_address_o,
    output logic [511:0]                l2req_data_o,
    output logic [63:0]                 l2req_mask_o,
    output logic [CORE_ID_WIDTH-1:0]    l2req_core_o,
    input  logic                        l2req_ack_i,
    output logic [32*NUM_CORES-1:0]     grant_count_o,
    output logic [31:0]                 contention_count_o
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [CORE_ID_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic [CORE_ID_WIDTH-1:0]   last_id_q, last_id_d;

    logic [NUM_CORES-1:0]       grant_oh;
    logic [NUM_CORES-1:0]       cand;
    logic                       win_found;
    logic [CORE_ID_WIDTH-1:0]   win_id;

    function automatic logic [CORE_ID_WIDTH-1:0] wrap_idx(
        input logic [CORE_ID_WIDTH-1:0] base,
        input int                       off
    );
        int s;
        s = int'(base) + off;
        if (s >= NUM_CORES) s = s - NUM_CORES;
        return CORE_ID_WIDTH'(s);
    endfunction

    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            grant_oh[i] = (state_q == ST_GRANTED) && (grant_id_q == CORE_ID_WIDTH'(i));
        end
    end

    // The granted core is excluded: its valid is stale during its own ack cycle.
    always_comb begin
        cand      = core_l2req_valid_i & ~grant_oh;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            if (!win_found && cand[wrap_idx(last_id_q, k)]) begin
                win_found = 1'b1;
                win_id    = wrap_idx(last_id_q, k);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            grant_id_q <= '0;
            last_id_q  <= CORE_ID_WIDTH'(NUM_CORES - 1);
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d    = ST_GRANTED;
                    grant_id_d = win_id;
                    last_id_d  = win_id;
                end
            end
            ST_GRANTED: begin
                if (l2req_ack_i) begin
                    if (win_found) begin
                        grant_id_d = win_id;
                        last_id_d  = win_id;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        l2req_valid_o   = 1'b0;
        l2req_strand_o  = '0;
        l2req_unit_o    = '0;
        l2req_op_o      = '0;
        l2req_way_o     = '0;
        l2req_address_o = '0;
        l2req_data_o    = '0;
        l2req_mask_o    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant_oh[i]) begin
                l2req_valid_o   = core_l2req_valid_i[i];
                l2req_strand_o  = core_l2req_strand_i[i*2 +: 2];
                l2req_unit_o    = core_l2req_unit_i[i*2 +: 2];
                l2req_op_o      = core_l2req_op_i[i*3 +: 3];
                l2req_way_o     = core_l2req_way_i[i*2 +: 2];
                l2req_address_o = core_l2req_address_i[i*26 +: 26];
                l2req_data_o    = core_l2req_data_i[i*512 +: 512];
                l2req_mask_o    = core_l2req_mask_i[i*64 +: 64];
            end
        end
    end

    assign l2req_core_o     = (state_q == ST_GRANTED) ? grant_id_q : '0;
    assign core_l2req_ack_o = grant_oh & {NUM_CORES{l2req_ack_i}};

`ifdef L2REQ_ARB_PERF_COUNTERS_EN
    logic [31:0] contention_q;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_cnt
        logic [31:0] cnt_q;
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                cnt_q <= '0;
            end else if (core_l2req_ack_o[g]) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
        assign grant_count_o[g*32 +: 32] = cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            contention_q <= '0;
        end else if (l2req_valid_o && (|(core_l2req_valid_i & ~grant_oh))) begin
            contention_q <= contention_q + 32'd1;
        end
    end
    assign contention_count_o = contention_q;
`else
    assign grant_count_o      = '0;
    assign contention_count_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2req_core_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_l2req_core_arbiter
// Purpose  : Directed self-checking bench for l2req_core_arbiter (4 cores).
// Revision : 1.0  initial release
// =============================================================================
module tb_l2req_core_arbiter;

    logic           clk;
    logic           rst;
    logic [3:0]     v;
    logic [7:0]     strand, unit, way;
    logic [11:0]    op;
    logic [103:0]   addr;
    logic [2047:0]  data;
    logic [255:0]   mask;
    logic           l2ack;

    logic [3:0]     ack_o;
    logic           valid_o;
    logic [1:0]     strand_o, unit_o, way_o;
    logic [2:0]     op_o;
    logic [25:0]    addr_o;
    logic [511:0]   data_o;
    logic [63:0]    mask_o;
    logic [1:0]     core_o;
    logic [127:0]   gcnt_o;
    logic [31:0]    cont_o;

    int n_cmp  = 0;
    int n_fail = 0;

    l2req_core_arbiter #(.NUM_CORES(4), .CORE_ID_WIDTH(2)) dut (
        .clk_i                (clk),
        .reset_i              (rst),
        .core_l2req_valid_i   (v),
        .core_l2req_strand_i  (strand),
        .core_l2req_unit_i    (unit),
        .core_l2req_op_i      (op),
        .core_l2req_way_i     (way),
        .core_l2req_address_i (addr),
        .core_l2req_data_i    (data),
        .core_l2req_mask_i    (mask),
        .core_l2req_ack_o     (ack_o),
        .l2req_valid_o        (valid_o),
        .l2req_strand_o       (strand_o),
        .l2req_unit_o         (unit_o),
        .l2req_op_o           (op_o),
        .l2req_way_o          (way_o),
        .l2req_address_o      (addr_o),
        .l2req_data_o         (data_o),
        .l2req_mask_o         (mask_o),
        .l2req_core_o         (core_o),
        .l2req_ack_i          (l2ack),
        .grant_count_o        (gcnt_o),
        .contention_count_o   (cont_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who holds the port, and the round-robin pointer.
    bit          m_init = 1'b0;
    bit          m_gr   = 1'b0;
    int          m_id   = 0;
    int          m_last = 3;
    logic [31:0] m_gcnt [4];
    logic [31:0] m_cont = '0;
    bit          pre_on   = 1'b0;
    logic [31:0] pre_snap = '0;

    function automatic int pick(input logic [3:0] req, input int excl, input int last);
        int c;
        for (int k = 1; k <= 4; k++) begin
            c = (last + k) % 4;
            if (req[c] && c != excl) return c;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_gcnt(input int i);
        if (pre_on && i == 0) return m_gcnt[0] - pre_snap + 32'hFFFF_FFFF;
        return m_gcnt[i];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_init <= 1'b1;
            m_gr   <= 1'b0;
            m_id   <= 0;
            m_last <= 3;
            m_cont <= '0;
            for (int i = 0; i < 4; i++) m_gcnt[i] <= '0;
        end else if (m_init) begin
`ifdef L2REQ_ARB_PERF_COUNTERS_EN
            if (m_gr && l2ack) m_gcnt[m_id] <= m_gcnt[m_id] + 32'd1;
            if (m_gr && v[m_id] && ((v & ~(4'b0001 << m_id)) != 4'b0000)) m_cont <= m_cont + 32'd1;
`endif
            if (!m_gr || l2ack) begin
                if (pick(v, (m_gr && l2ack) ? m_id : -1, m_last) >= 0) begin
                    m_gr   <= 1'b1;
                    m_id   <= pick(v, (m_gr && l2ack) ? m_id : -1, m_last);
                    m_last <= pick(v, (m_gr && l2ack) ? m_id : -1, m_last);
                end else begin
                    m_gr <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("l2req_valid", valid_o, m_gr ? v[m_id] : 1'b0);
            chk("l2req_core", core_o, m_gr ? m_id[1:0] : 2'd0);
            chk("core_ack", ack_o, (m_gr && l2ack) ? (4'b0001 << m_id) : 4'b0000);
            chk("strand", strand_o, m_gr ? strand[m_id*2 +: 2] : 2'd0);
            chk("unit", unit_o, m_gr ? unit[m_id*2 +: 2] : 2'd0);
            chk("op", op_o, m_gr ? op[m_id*3 +: 3] : 3'd0);
            chk("way", way_o, m_gr ? way[m_id*2 +: 2] : 2'd0);
            chk("address", addr_o, m_gr ? addr[m_id*26 +: 26] : 26'd0);
            chk("data", data_o, m_gr ? data[m_id*512 +: 512] : 512'd0);
            chk("mask", mask_o, m_gr ? mask[m_id*64 +: 64] : 64'd0);
            for (int i = 0; i < 4; i++) chk("grant_count", gcnt_o[i*32 +: 32], exp_gcnt(i));
            chk("contention_count", cont_o, m_cont);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int order [$];

    initial begin
        rst = 1'b1; v = '0; l2ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            strand[i*2 +: 2]  = 2'(i);
            unit[i*2 +: 2]    = 2'(3 - i);
            op[i*3 +: 3]      = 3'(i + 1);
            way[i*2 +: 2]     = 2'(i ^ 1);
            addr[i*26 +: 26]  = (i == 2) ? 26'h0001234 : 26'h2A00000 + 26'(i);
            data[i*512 +: 512] = {16{32'hC0DE_0000 + 32'(i)}};
            mask[i*64 +: 64]   = {2{32'hF0F0_0000 + 32'(i)}};
        end
        repeat (3) tick();
        @(negedge clk);
        chk("reset_valid", valid_o, 1'b0);
        chk("reset_core", core_o, 2'd0);
        tick();

        // Core 2 alone.
        rst = 1'b0; v = 4'b0100;
        tick();
        @(negedge clk);
        chk("t1_valid", valid_o, 1'b1);
        chk("t1_core", core_o, 2'd2);
        chk("t1_addr", addr_o, 26'h0001234);
        tick(); l2ack = 1'b1;
        @(negedge clk);
        chk("t1_ack", ack_o, 4'b0100);
        tick(); v = '0; l2ack = 1'b0;
        @(negedge clk);
        chk("t1_valid_after", valid_o, 1'b0);

        // All four cores, ack every cycle, from fresh reset.
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; v = 4'b1111; l2ack = 1'b1;
        for (int c = 0; c < 20 && order.size() < 8; c++) begin
            @(negedge clk);
            if (valid_o) order.push_back(int'(core_o));
            tick();
        end
        chk("t2_grants", 32'(order.size()), 32'd8);
        for (int k = 0; k < order.size(); k++) chk("t2_order", 32'(order[k]), 32'(k % 4));
`ifdef L2REQ_ARB_PERF_COUNTERS_EN
        for (int i = 0; i < 4; i++) chk("t2_gcnt", gcnt_o[i*32 +: 32], 32'd2);
`endif
        v = 4'b0001;
        tick(); v = '0; l2ack = 1'b0;

        // Hold core 1 unacked while core 3 waits.
        v = 4'b0010;
        tick(); v = 4'b1010;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t3_hold_core", core_o, 2'd1);
            chk("t3_hold_valid", valid_o, 1'b1);
            tick();
        end
        l2ack = 1'b1;
        tick(); v = 4'b1000; l2ack = 1'b0;
        @(negedge clk);
        chk("t3_next_core", core_o, 2'd3);
        tick(); l2ack = 1'b1;
        tick(); v = '0; l2ack = 1'b0;
        tick();

        // Sole requester re-requesting: one bubble.
        v = 4'b0001;
        tick(); l2ack = 1'b1;
        tick(); l2ack = 1'b0;
        @(negedge clk);
        chk("t4_bubble", valid_o, 1'b0);
        tick();
        @(negedge clk);
        chk("t4_regrant", valid_o, 1'b1);
        chk("t4_core", core_o, 2'd0);
        tick(); l2ack = 1'b1;
        tick(); v = '0; l2ack = 1'b0;
        tick();

        // Reset while core 3 is granted.
        v = 4'b1000;
        tick();
        @(negedge clk);
        chk("t5_core3", core_o, 2'd3);
        tick(); rst = 1'b1;
        tick(); l2ack = 1'b1;
        @(negedge clk);
        chk("t5_rst_valid", valid_o, 1'b0);
        chk("t5_rst_ack", ack_o, 4'b0000);
        tick(); rst = 1'b0; v = 4'b1001; l2ack = 1'b0;
        tick();
        @(negedge clk);
        chk("t5_first", core_o, 2'd0);
        tick(); l2ack = 1'b1;
        tick(); v = 4'b1000;
        tick(); v = '0; l2ack = 1'b0;
        tick();

`ifdef L2REQ_ARB_PERF_COUNTERS_EN
        // Counter wrap on core 0.
        force dut.g_cnt[0].cnt_q = 32'hFFFF_FFFF;
        pre_snap = m_gcnt[0];
        pre_on   = 1'b1;
        #1;
        release dut.g_cnt[0].cnt_q;
        v = 4'b0001;
        tick(); l2ack = 1'b1;
        tick(); v = '0; l2ack = 1'b0;
        chk("t6_wrap", gcnt_o[31:0], 32'd0);
        tick();
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
